mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: a multiply/divide or move-to-HI/LO request from the E stage is valid this cycle.
REQ-004 SHALL have port cancel, input, 1 bit: the E-stage instruction is being flushed by an exception/interrupt; when high, start is ignored.
REQ-005 SHALL have port mdOp, input, 3 bits: operation code MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-006 SHALL have port A, input, 32 bits: forwarded rs operand.
REQ-007 SHALL have port B, input, 32 bits: forwarded rt operand.
REQ-008 SHALL have port busy, output, 1 bit: an operation is in flight.
REQ-009 SHALL have port HI, output, 32 bits: architectural HI register.
REQ-010 SHALL have port LO, output, 32 bits: architectural LO register.

Function
REQ-011 SHALL have two states: IDLE and BUSY, plus a 4-bit down-counter cnt.
REQ-012 SHALL accept a request in IDLE when start=1 and cancel=0; any other combination is no request.
REQ-013 SHALL, on an accepted MULT/MULTU, latch the operands, enter BUSY, and load cnt=5.
REQ-014 SHALL, on an accepted DIV/DIVU, latch the operands, enter BUSY, and load cnt=10.
REQ-015 SHALL hold busy=1 for exactly N cycles after the accepting edge (N=5 mult, 10 div); busy is registered, not a function of start.
REQ-016 SHALL decrement cnt each cycle in BUSY; at the edge where cnt goes 1->0, write HI/LO and return to IDLE, so results are visible in the first cycle with busy=0.
REQ-017 SHALL compute MULT as a signed 32x32->64 product and MULTU as unsigned; HI=bits[63:32], LO=bits[31:0].
REQ-018 SHALL compute DIV as signed with quotient truncated toward zero and remainder taking the sign of the dividend; DIVU unsigned; LO=quotient, HI=remainder.
REQ-019 SHALL leave HI and LO unchanged when a DIV/DIVU divisor is 0; the busy period still runs its full 10 cycles.
REQ-020 SHALL produce LO=0x80000000, HI=0 for DIV 0x80000000 / 0xFFFFFFFF.
REQ-021 SHALL, on an accepted MTHI/MTLO, write A to HI/LO at that same edge, without entering BUSY.
REQ-022 SHALL ignore start while BUSY; the hazard unit stalls D on (busy | start) with an MD-class instruction, so this case is illegal but harmless.
REQ-023 SHALL NOT allow cancel to abort an operation already in BUSY; it gates acceptance only.
REQ-024 SHALL drive HI and LO directly from registers, with no combinational path from A or B.

Reset
REQ-025 SHALL, while reset=0, asynchronously force state=IDLE, cnt=0, busy=0, HI=0, LO=0, and clear the operand latches.
REQ-026 SHALL discard an in-flight operation if reset asserts during it; HI/LO read 0 afterwards.
REQ-027 SHALL begin accepting requests on the first rising edge after reset deasserts.

Structure
REQ-028 SHALL take the mdOp encodings and the latency constants (MULT_CYC=5, DIV_CYC=10) from the shared define.v header, alongside the forwarding select codes.
REQ-029 SHALL be a single module with no sub-modules; the 64-bit result is computed at acceptance into a pending register and committed at cnt 1->0.

Verification
REQ-030 SHALL cover MULT with A=0xFFFFFFFE (-2), B=3: busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
REQ-031 SHALL cover DIV with A=0xFFFFFFF9 (-7), B=2: busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 gives busy for 10 cycles with HI/LO unchanged.
REQ-032 SHALL cover MTHI with A=0x12345678 and MTLO with A=0x9ABCDEF0 in consecutive cycles: HI/LO updated on each edge and busy never asserted.
REQ-033 SHALL cover start=1 with cancel=1 on MULT: busy stays 0 and HI/LO are unchanged; start pulsed during BUSY: the original result is committed and the second request is dropped.
REQ-034 SHALL cover reset asserted in cycle 3 of a DIV: busy, HI and LO go to 0 immediately (asynchronously), and a new MULT after release completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared MD-unit definitions: operation encodings, latencies and forwarding select codes.
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_NOP   = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } mdOp_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mduState_e;

    localparam logic [3:0] MULT_CYC = 4'd5;
    localparam logic [3:0] DIV_CYC  = 4'd10;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_EM = 2'd1;
    localparam logic [1:0] FWD_MW = 2'd2;

    // Returns {remainder, quotient}; a zero divisor yields a don't-care value that is never committed.
    function automatic logic [63:0] divMod(input logic [31:0] a, input logic [31:0] b,
                                           input logic isSigned);
        logic        negA;
        logic        negB;
        logic [31:0] magA;
        logic [31:0] magB;
        logic [31:0] q;
        logic [31:0] r;
        negA = isSigned & a[31];
        negB = isSigned & b[31];
        magA = negA ? -a : a;
        magB = negB ? -b : b;
        if (magB == 32'd0) magB = 32'd1;
        q = magA / magB;
        r = magA % magB;
        if (negA ^ negB) q = -q;
        if (negA) r = -r;
        return {r, q};
    endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO: fixed-latency busy window, result
// computed at acceptance and committed when the down-counter expires.
module mdu
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cancel,
    input  logic [2:0]  mdOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    mduState_e   r_state;
    mduState_e   w_nextState;
    logic [3:0]  r_cnt;
    logic [3:0]  w_nextCnt;
    mdOp_e       r_op;
    logic [31:0] r_opA;
    logic [31:0] r_opB;
    logic [63:0] r_pend;
    logic [63:0] w_result;
    logic        w_accept;
    logic        w_isMul;
    logic        w_isDiv;
    logic        w_commit;
    logic        w_divZero;
    logic        w_divOvf;

    assign w_accept = (r_state == S_IDLE) && start && !cancel;
    assign w_isMul  = w_accept && ((mdOp == MD_MULT) || (mdOp == MD_MULTU));
    assign w_isDiv  = w_accept && ((mdOp == MD_DIV) || (mdOp == MD_DIVU));
    assign busy     = (r_state == S_BUSY);

    always_comb begin
        w_result = 64'd0;
        case (mdOp)
            MD_MULT:  w_result = {{32{A[31]}}, A} * {{32{B[31]}}, B};
            MD_MULTU: w_result = {32'd0, A} * {32'd0, B};
            MD_DIV:   w_result = divMod(A, B, 1'b1);
            MD_DIVU:  w_result = divMod(A, B, 1'b0);
            default:  w_result = 64'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_isMul) begin
                    w_nextState = S_BUSY;
                    w_nextCnt   = MULT_CYC;
                end else if (w_isDiv) begin
                    w_nextState = S_BUSY;
                    w_nextCnt   = DIV_CYC;
                end
            end
            S_BUSY: begin
                w_nextCnt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_nextState = S_IDLE;
                    w_commit    = 1'b1;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op   <= MD_NOP;
            r_opA  <= 32'd0;
            r_opB  <= 32'd0;
            r_pend <= 64'd0;
        end else if (w_isMul || w_isDiv) begin
            r_op   <= mdOp_e'(mdOp);
            r_opA  <= A;
            r_opB  <= B;
            r_pend <= w_result;
        end
    end

    // The signed-overflow quotient is pinned from the latched operands rather than trusted to the divider.
    assign w_divZero = ((r_op == MD_DIV) || (r_op == MD_DIVU)) && (r_opB == 32'd0);
    assign w_divOvf  = (r_op == MD_DIV) && (r_opA == 32'h8000_0000) && (r_opB == 32'hFFFF_FFFF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HI <= 32'd0;
            LO <= 32'd0;
        end else if (w_commit) begin
            if (!w_divZero) begin
                HI <= w_divOvf ? 32'd0 : r_pend[63:32];
                LO <= w_divOvf ? 32'h8000_0000 : r_pend[31:0];
            end
        end else if (w_accept && (mdOp == MD_MTHI)) begin
            HI <= A;
        end else if (w_accept && (mdOp == MD_MTLO)) begin
            LO <= A;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Scoreboarded bench for mdu: stimulus pushes model results, a negedge monitor checks each completion.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        start  = 1'b0;
    logic        cancel = 1'b0;
    logic [2:0]  mdOp   = 3'd0;
    logic [31:0] A      = 32'd0;
    logic [31:0] B      = 32'd0;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    always #5 clk = ~clk;

    mdu dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .cancel (cancel),
        .mdOp   (mdOp),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        string       name;
    } exp_t;

    exp_t        expQ[$];
    int          nCompared = 0;
    int          nFailed   = 0;
    logic [31:0] refHi     = 32'd0;
    logic [31:0] refLo     = 32'd0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic string opName(input logic [2:0] op);
        case (op)
            MD_MULT:  return "MULT";
            MD_MULTU: return "MULTU";
            MD_DIV:   return "DIV";
            MD_DIVU:  return "DIVU";
            MD_MTHI:  return "MTHI";
            MD_MTLO:  return "MTLO";
            default:  return "NOP";
        endcase
    endfunction

    // Architectural reference: plain 64-bit arithmetic on the HI/LO pair.
    task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int cycles);
        int                ia;
        int                ib;
        longint            sa;
        longint            sb;
        longint            sq;
        longint            sr;
        longint unsigned   uq;
        longint unsigned   ur;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        cycles = 0;
        case (op)
            MD_MULT: begin
                sq = sa * sb;
                {refHi, refLo} = sq;
                cycles = 5;
            end
            MD_MULTU: begin
                uq = {32'd0, a} * {32'd0, b};
                {refHi, refLo} = uq;
                cycles = 5;
            end
            MD_DIV: begin
                cycles = 10;
                if (b != 32'd0) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    refLo = sq[31:0];
                    refHi = sr[31:0];
                end
            end
            MD_DIVU: begin
                cycles = 10;
                if (b != 32'd0) begin
                    uq = {32'd0, a} / {32'd0, b};
                    ur = {32'd0, a} % {32'd0, b};
                    refLo = uq[31:0];
                    refHi = ur[31:0];
                end
            end
            MD_MTHI: refHi = a;
            MD_MTLO: refLo = a;
            default: cycles = 0;
        endcase
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("busy timeout", {31'd0, busy}, 32'd0);
    endtask

    // Drives one request for exactly one edge; mul/div expectations go to the scoreboard.
    task automatic issueOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        mdOp   = op;
        A      = a;
        B      = b;
        start  = 1'b1;
        cancel = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        modelOp(op, a, b, cyc);
        if (cyc > 0) begin
            expQ.push_back('{refHi, refLo, cyc, opName(op)});
            checkOutput({opName(op), " busy after accept"}, {31'd0, busy}, 32'd1);
        end else begin
            checkOutput({opName(op), " HI"}, HI, refHi);
            checkOutput({opName(op), " LO"}, LO, refLo);
            checkOutput({opName(op), " busy"}, {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        issueOp(op, a, b);
        if (op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) waitIdle();
    endtask

    initial begin : monitor
        int   runLen = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                runLen = 0;
            end else if (busy) begin
                runLen++;
            end else if (runLen > 0) begin
                if (expQ.size() == 0) begin
                    nCompared++;
                    nFailed++;
                    $display("[TB] FAIL unexpected completion: busy ran %0d cycles, nothing expected",
                             runLen);
                end else begin
                    e = expQ.pop_front();
                    checkOutput({e.name, " HI"}, HI, e.hi);
                    checkOutput({e.name, " LO"}, LO, e.lo);
                    checkOutput({e.name, " busy cycles"}, runLen, e.cycles);
                end
                runLen = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        #1 reset = 1'b0;
        #10;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset HI", HI, 32'd0);
        checkOutput("reset LO", LO, 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;

        applyStimulus(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        checkOutput("MULT -2*3 HI const", HI, 32'hFFFF_FFFF);
        checkOutput("MULT -2*3 LO const", LO, 32'hFFFF_FFFA);
        applyStimulus(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
        checkOutput("MULTU HI const", HI, 32'h0000_0002);
        checkOutput("MULTU LO const", LO, 32'hFFFF_FFFA);

        applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        checkOutput("DIV -7/2 LO const", LO, 32'hFFFF_FFFD);
        checkOutput("DIV -7/2 HI const", HI, 32'hFFFF_FFFF);
        applyStimulus(MD_DIVU, 32'd7, 32'd0);
        checkOutput("DIVU 7/0 HI const", HI, 32'hFFFF_FFFF);
        checkOutput("DIVU 7/0 LO const", LO, 32'hFFFF_FFFD);

        applyStimulus(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("DIV ovf LO const", LO, 32'h8000_0000);
        checkOutput("DIV ovf HI const", HI, 32'h0000_0000);

        @(negedge clk);
        issueOp(MD_MTHI, 32'h1234_5678, 32'd0);
        issueOp(MD_MTLO, 32'h9ABC_DEF0, 32'd0);
        checkOutput("MTHI HI const", HI, 32'h1234_5678);

        // Cancelled request must not start anything.
        mdOp   = MD_MULT;
        A      = 32'd5;
        B      = 32'd7;
        start  = 1'b1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
        checkOutput("cancel busy", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        checkOutput("cancel busy later", {31'd0, busy}, 32'd0);
        checkOutput("cancel HI", HI, refHi);
        checkOutput("cancel LO", LO, refLo);

        // A second request while busy is dropped.
        issueOp(MD_MULT, 32'd100, 32'd200);
        @(posedge clk);
        #1;
        mdOp  = MD_DIV;
        A     = 32'd1000;
        B     = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitIdle();
        repeat (3) @(negedge clk);
        checkOutput("dropped req busy", {31'd0, busy}, 32'd0);
        checkOutput("dropped req HI", HI, refHi);
        checkOutput("dropped req LO", LO, refLo);

        // Reset in the third busy cycle of a DIV.
        @(negedge clk);
        issueOp(MD_DIV, 32'd100, 32'd7);
        void'(expQ.pop_back());
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checkOutput("mid-reset busy", {31'd0, busy}, 32'd0);
        checkOutput("mid-reset HI", HI, 32'd0);
        checkOutput("mid-reset LO", LO, 32'd0);
        refHi = 32'd0;
        refLo = 32'd0;
        @(negedge clk);
        #2 reset = 1'b1;
        applyStimulus(MD_MULT, 32'd6, 32'd7);
        checkOutput("post-reset MULT LO const", LO, 32'd42);

        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            op = 3'($urandom_range(1, 6));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            applyStimulus(op, a, b);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", expQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
